// File: rtl/wmst_from_out_fifo_tile_pkg.sv
// Shared definitions for the output-tile store path: default sizes,
// lane/byte helpers and the control FSM state encoding.
package wmst_from_out_fifo_tile_pkg;

    localparam int DEF_CW   = 16;
    localparam int DEF_DW   = 32;
    localparam int DEF_XAW  = 32;
    localparam int DEF_XDW  = 128;
    localparam int DEF_BLEN = 8;

    // Number of FIFO words packed into one write-master beat (WCNT).
    function automatic int lanes_of(input int xdw, input int dw);
        return xdw / dw;
    endfunction

    // Bytes carried by one FIFO word.
    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } tile_state_e;

endpackage

// File: rtl/wmst_beat_packer.sv
// Packs FIFO words into write-master beats, word 0 in the LSB lane.
// Handshake: store_fifo_pop is a request that the FIFO honours whenever
// it is not empty; the popped word arrives one cycle later. On the
// master side buf_write is a valid strobe that is only raised when
// buf_full is low, so every strobe is one accepted beat; the beat data
// is held stable for as long as the beat is pending.
module wmst_beat_packer
    import wmst_from_out_fifo_tile_pkg::*;
#(
    parameter int CW  = DEF_CW,
    parameter int DW  = DEF_DW,
    parameter int XDW = DEF_XDW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           active,
    input  logic           load,
    input  logic [CW-1:0]  oolen,
    output logic           fifo_pop,
    input  logic [DW-1:0]  fifo_data,
    input  logic           fifo_empty,
    output logic           buf_write,
    output logic [XDW-1:0] buf_data,
    input  logic           buf_full
);

    localparam int LANES = lanes_of(XDW, DW);
    localparam int LW    = $clog2(LANES + 1);

    logic [CW-1:0]  pop_rem_q, pop_rem_d;
    logic [LW-1:0]  pops_q, pops_d;
    logic [LW-1:0]  cap_lane_q, cap_lane_d;
    logic           pend_q, pend_d;
    logic [XDW-1:0] beat_q, beat_d;
    logic           beat_valid_q, beat_valid_d;
    logic           push;

    // Pop only real words, one beat at a time, never while a beat waits.
    always_comb begin
        fifo_pop = active && !fifo_empty && (pop_rem_q != '0) &&
                   (pops_q < LW'(LANES)) && !beat_valid_q;
        push     = beat_valid_q && !buf_full;
    end

    // Lane capture, beat completion (last lane or last real word) and push.
    always_comb begin
        pop_rem_d    = pop_rem_q;
        pops_d       = pops_q;
        cap_lane_d   = cap_lane_q;
        pend_d       = 1'b0;
        beat_d       = beat_q;
        beat_valid_d = beat_valid_q;
        if (load) begin
            pop_rem_d    = oolen;
            pops_d       = '0;
            cap_lane_d   = '0;
            beat_d       = '0;
            beat_valid_d = 1'b0;
        end else begin
            if (push) begin
                beat_valid_d = 1'b0;
                pops_d       = '0;
                beat_d       = '0;
            end
            if (pend_q) begin
                beat_d[cap_lane_q*DW +: DW] = fifo_data;
                // Pad lanes are already zero because the beat clears on push.
                if ((cap_lane_q == LW'(LANES - 1)) || (pop_rem_q == '0)) begin
                    beat_valid_d = 1'b1;
                end
            end
            if (fifo_pop) begin
                pop_rem_d  = pop_rem_q - CW'(1);
                pops_d     = pops_q + LW'(1);
                cap_lane_d = pops_q;
            end
            pend_d = fifo_pop;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_rem_q    <= '0;
            pops_q       <= '0;
            cap_lane_q   <= '0;
            pend_q       <= 1'b0;
            beat_q       <= '0;
            beat_valid_q <= 1'b0;
        end else begin
            pop_rem_q    <= pop_rem_d;
            pops_q       <= pops_d;
            cap_lane_q   <= cap_lane_d;
            pend_q       <= pend_d;
            beat_q       <= beat_d;
            beat_valid_q <= beat_valid_d;
        end
    end

    assign buf_write = push;
    assign buf_data  = beat_q;

endmodule

// File: rtl/wmst_from_out_fifo_tile.sv
// Stores one output tile from the output FIFO to external memory: the
// packer streams beats into the write master buffer while the control
// FSM issues one go per burst of up to BLEN words.
module wmst_from_out_fifo_tile
    import wmst_from_out_fifo_tile_pkg::*;
#(
    parameter int CW   = DEF_CW,
    parameter int DW   = DEF_DW,
    parameter int XAW  = DEF_XAW,
    parameter int XDW  = DEF_XDW,
    parameter int BLEN = DEF_BLEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           store_start,
    input  logic [XAW-1:0] param_waddr,
    input  logic [CW-1:0]  param_oolen,
    output logic           store_done,
    output logic           store_fifo_pop,
    input  logic [DW-1:0]  store_fifo_data,
    input  logic           store_fifo_empty,
    output logic           wmst_fixed_location,
    output logic [XAW-1:0] wmst_write_base,
    output logic [XAW-1:0] wmst_write_length,
    output logic           wmst_go,
    input  logic           wmst_done,
    output logic           wmst_user_write_buffer,
    output logic [XDW-1:0] wmst_user_buffer_data,
    input  logic           wmst_user_buffer_full
);

    localparam int LANES = lanes_of(XDW, DW);
    localparam int BPW   = bytes_of(DW);

    tile_state_e    state_q, state_d;
    logic [XAW-1:0] addr_q, addr_d;
    logic [CW-1:0]  rem_q, rem_d;
    logic           done_prev_q, done_prev_d;
    logic           store_done_q, store_done_d;

    logic [CW:0]    oolen_ext;
    logic [CW-1:0]  words_rnd;
    logic [CW-1:0]  burst_words;
    logic [XAW-1:0] burst_bytes;
    logic           done_rise;
    logic           start_ok;

    // Tile length rounded up to whole beats, and the current burst size.
    always_comb begin
        oolen_ext   = {1'b0, param_oolen} + (CW+1)'(LANES - 1);
        words_rnd   = CW'((oolen_ext / (CW+1)'(LANES)) * (CW+1)'(LANES));
        burst_words = (rem_q > CW'(BLEN)) ? CW'(BLEN) : rem_q;
        burst_bytes = XAW'(burst_words) * XAW'(BPW);
        done_rise   = wmst_done && !done_prev_q;
        start_ok    = store_start && (state_q == ST_IDLE);
        done_prev_d = wmst_done;
    end

    // Next-state logic: start, issue a burst, wait for its completion edge.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        store_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (store_start) begin
                    addr_d = param_waddr;
                    rem_d  = words_rnd;
                    if (words_rnd != '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        store_done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                addr_d  = addr_q + burst_bytes;
                rem_d   = rem_q - burst_words;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    if (rem_q != '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        store_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            done_prev_q  <= 1'b0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            done_prev_q  <= done_prev_d;
            store_done_q <= store_done_d;
        end
    end

    // Burst command outputs are only driven during the go cycle.
    always_comb begin
        wmst_go           = 1'b0;
        wmst_write_base   = '0;
        wmst_write_length = '0;
        if (state_q == ST_ISSUE) begin
            wmst_go           = 1'b1;
            wmst_write_base   = addr_q;
            wmst_write_length = burst_bytes;
        end
    end

    assign store_done          = store_done_q;
    assign wmst_fixed_location = 1'b0;

    wmst_beat_packer #(
        .CW  (CW),
        .DW  (DW),
        .XDW (XDW)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .active     (state_q != ST_IDLE),
        .load       (start_ok),
        .oolen      (param_oolen),
        .fifo_pop   (store_fifo_pop),
        .fifo_data  (store_fifo_data),
        .fifo_empty (store_fifo_empty),
        .buf_write  (wmst_user_write_buffer),
        .buf_data   (wmst_user_buffer_data),
        .buf_full   (wmst_user_buffer_full)
    );

endmodule

// File: tb/tb_wmst_from_out_fifo_tile.sv
// Bench for wmst_from_out_fifo_tile: FIFO and write-master models,
// a beat/burst reference computed from the tile length, directed tiles.
module tb_wmst_from_out_fifo_tile;

    localparam int CW         = 16;
    localparam int DW         = 32;
    localparam int XAW        = 32;
    localparam int XDW        = 128;
    localparam int BLEN       = 8;
    localparam int LANES      = XDW / DW;
    localparam int BEAT_BYTES = XDW / 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           store_start;
    logic [XAW-1:0] param_waddr;
    logic [CW-1:0]  param_oolen;
    logic           store_done;
    logic           store_fifo_pop;
    logic [DW-1:0]  store_fifo_data;
    logic           store_fifo_empty;
    logic           wmst_fixed_location;
    logic [XAW-1:0] wmst_write_base;
    logic [XAW-1:0] wmst_write_length;
    logic           wmst_go;
    logic           wmst_done;
    logic           wmst_user_write_buffer;
    logic [XDW-1:0] wmst_user_buffer_data;
    logic           wmst_user_buffer_full;

    int n_cmp = 0;
    int n_bad = 0;

    // Models and monitors state.
    logic [DW-1:0]  fifo_q[$];
    logic [XDW-1:0] got_beats[$];
    logic [XAW-1:0] got_base[$];
    logic [XAW-1:0] got_len[$];
    logic [XDW-1:0] exp_q[$];
    logic [XAW-1:0] exp_base[$];
    logic [XAW-1:0] exp_len[$];
    int  pop_total, bad_pop, bad_push, late_resp, done_pulses;
    int  pushed_total, need_beats, done_dly;
    bit  done_armed, rise_prev, pop_seen;
    int  empty_pct;
    int  cyc;
    int  full_from;

    wmst_from_out_fifo_tile #(
        .CW(CW), .DW(DW), .XAW(XAW), .XDW(XDW), .BLEN(BLEN)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .store_start            (store_start),
        .param_waddr            (param_waddr),
        .param_oolen            (param_oolen),
        .store_done             (store_done),
        .store_fifo_pop         (store_fifo_pop),
        .store_fifo_data        (store_fifo_data),
        .store_fifo_empty       (store_fifo_empty),
        .wmst_fixed_location    (wmst_fixed_location),
        .wmst_write_base        (wmst_write_base),
        .wmst_write_length      (wmst_write_length),
        .wmst_go                (wmst_go),
        .wmst_done              (wmst_done),
        .wmst_user_write_buffer (wmst_user_write_buffer),
        .wmst_user_buffer_data  (wmst_user_buffer_data),
        .wmst_user_buffer_full  (wmst_user_buffer_full)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor and write-master model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            wmst_done  = 1'b0;
            done_armed = 1'b0;
            rise_prev  = 1'b0;
        end else begin
            if (rise_prev && !(wmst_go || store_done)) late_resp++;
            rise_prev = 1'b0;
            if (store_fifo_pop) begin
                pop_total++;
                if (store_fifo_empty) bad_pop++;
                pop_seen = 1'b1;
            end
            if (wmst_user_write_buffer) begin
                if (wmst_user_buffer_full) bad_push++;
                got_beats.push_back(wmst_user_buffer_data);
                pushed_total++;
            end
            if (store_done) done_pulses++;
            if (wmst_go) begin
                got_base.push_back(wmst_write_base);
                got_len.push_back(wmst_write_length);
                need_beats += int'(wmst_write_length) / BEAT_BYTES;
                wmst_done  = 1'b0;
                done_armed = 1'b1;
                done_dly   = $urandom_range(2, 6);
            end else if (done_armed) begin
                if (done_dly > 0) begin
                    done_dly--;
                end else if (pushed_total >= need_beats) begin
                    wmst_done  = 1'b1;
                    done_armed = 1'b0;
                    rise_prev  = 1'b1;
                end
            end
        end
    end

    // FIFO model and buffer-full driver, updated just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (pop_seen) begin
            pop_seen = 1'b0;
            if (fifo_q.size() > 0) store_fifo_data = fifo_q.pop_front();
        end
        store_fifo_empty      = (fifo_q.size() == 0) || ($urandom_range(0, 99) < empty_pct);
        wmst_user_buffer_full = (cyc >= full_from) && (cyc < full_from + 10);
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [XDW-1:0] obs, input logic [XDW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_store_done"}, XDW'(store_done), '0);
        chk({tag, "_pop"}, XDW'(store_fifo_pop), '0);
        chk({tag, "_fixed"}, XDW'(wmst_fixed_location), '0);
        chk({tag, "_base"}, XDW'(wmst_write_base), '0);
        chk({tag, "_len"}, XDW'(wmst_write_length), '0);
        chk({tag, "_go"}, XDW'(wmst_go), '0);
        chk({tag, "_wrbuf"}, XDW'(wmst_user_write_buffer), '0);
        chk({tag, "_data"}, wmst_user_buffer_data, '0);
    endtask

    task automatic clear_mon();
        got_beats.delete();
        got_base.delete();
        got_len.delete();
        pop_total    = 0;
        bad_pop      = 0;
        bad_push     = 0;
        late_resp    = 0;
        done_pulses  = 0;
        pushed_total = 0;
        need_beats   = 0;
    endtask

    // Reference: beats from the word list, bursts from the rounded length.
    task automatic build_ref(input logic [XAW-1:0] waddr, input logic [DW-1:0] words[$]);
        int n, nw, rem, l;
        logic [XDW-1:0] beat;
        logic [XAW-1:0] addr;
        n  = words.size();
        nw = ((n + LANES - 1) / LANES) * LANES;
        exp_q.delete();
        exp_base.delete();
        exp_len.delete();
        for (int b = 0; b < nw / LANES; b++) begin
            beat = '0;
            for (int k = 0; k < LANES; k++) begin
                if (b * LANES + k < n) beat[k*DW +: DW] = words[b*LANES + k];
            end
            exp_q.push_back(beat);
        end
        addr = waddr;
        rem  = nw;
        while (rem > 0) begin
            l = (rem > BLEN) ? BLEN : rem;
            exp_base.push_back(addr);
            exp_len.push_back(XAW'(l * (DW / 8)));
            addr = addr + XAW'(l * (DW / 8));
            rem  = rem - l;
        end
    endtask

    task automatic run_tile(input logic [XAW-1:0] waddr, input int oolen, input int epct,
                            input int full_off, input bit seq, input string tag);
        logic [DW-1:0]  words[$];
        logic [XDW-1:0] g;
        for (int i = 0; i < oolen; i++) begin
            words.push_back(seq ? DW'(i) : DW'($urandom));
            fifo_q.push_back(words[i]);
        end
        build_ref(waddr, words);
        clear_mon();
        empty_pct = epct;
        full_from = (full_off < 0) ? 32'h7fff_0000 : cyc + full_off;
        tick();
        param_waddr = waddr;
        param_oolen = CW'(oolen);
        store_start = 1'b1;
        tick();
        store_start = 1'b0;
        @(negedge clk);
        if (oolen == 0) begin
            chk({tag, "_done_t1"}, XDW'(store_done), 1);
            chk({tag, "_nogo_t1"}, XDW'(wmst_go), 0);
        end else begin
            chk({tag, "_go_t1"}, XDW'(wmst_go), 1);
            chk({tag, "_base_t1"}, XDW'(wmst_write_base), XDW'(exp_base[0]));
            chk({tag, "_len_t1"}, XDW'(wmst_write_length), XDW'(exp_len[0]));
        end
        for (int c = 0; c < 3000 && done_pulses == 0; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk({tag, "_done_cnt"}, XDW'(done_pulses), 1);
        chk({tag, "_pops"}, XDW'(pop_total), XDW'(oolen));
        chk({tag, "_pop_when_empty"}, XDW'(bad_pop), 0);
        chk({tag, "_push_when_full"}, XDW'(bad_push), 0);
        chk({tag, "_late_go"}, XDW'(late_resp), 0);
        chk({tag, "_nbeats"}, XDW'(got_beats.size()), XDW'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_beats.size()) ? got_beats[i] : 'x;
            chk($sformatf("%s_beat%0d", tag, i), g, exp_q[i]);
        end
        chk({tag, "_ngo"}, XDW'(got_base.size()), XDW'(exp_base.size()));
        for (int i = 0; i < exp_base.size(); i++) begin
            g = (i < got_base.size()) ? XDW'(got_base[i]) : 'x;
            chk($sformatf("%s_go%0d_base", tag, i), g, XDW'(exp_base[i]));
            g = (i < got_len.size()) ? XDW'(got_len[i]) : 'x;
            chk($sformatf("%s_go%0d_len", tag, i), g, XDW'(exp_len[i]));
        end
    endtask

    // Directed sequence of tiles.
    initial begin
        logic [DW-1:0] rw;
        rst                   = 1'b1;
        store_start           = 1'b0;
        param_waddr           = '0;
        param_oolen           = '0;
        store_fifo_data       = '0;
        store_fifo_empty      = 1'b1;
        wmst_user_buffer_full = 1'b0;
        empty_pct             = 0;
        cyc                   = 0;
        full_from             = 32'h7fff_0000;
        pop_seen              = 1'b0;
        done_dly              = 0;
        clear_mon();
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        run_tile(32'h0000_1000, 16, 0, -1, 1'b1, "seq16");
        chk("seq16_beat0_const", got_beats.size() > 0 ? got_beats[0] : 'x,
            128'h00000003_00000002_00000001_00000000);
        chk("seq16_go1_base_const", got_base.size() > 1 ? XDW'(got_base[1]) : 'x,
            XDW'(32'h0000_1020));

        run_tile(32'h0000_4000, 24, 0, 8, 1'b0, "full_win");
        run_tile(32'h0000_8000, 20, 50, -1, 1'b0, "empty50");
        run_tile(32'h0000_9000, 0, 0, -1, 1'b0, "len0");
        chk("len0_no_go", XDW'(got_base.size()), 0);

        run_tile(32'h0000_a000, 6, 0, -1, 1'b1, "len6");
        chk("len6_beat1_const", got_beats.size() > 1 ? got_beats[1] : 'x,
            128'h00000000_00000000_00000005_00000004);

        run_tile(32'hffff_fff0, 16, 20, 5, 1'b0, "wrap");
        run_tile(32'h0001_0000, $urandom_range(1, 40), 30, 6, 1'b0, "rand");

        // Reset in the middle of the second burst.
        clear_mon();
        empty_pct = 0;
        full_from = 32'h7fff_0000;
        for (int i = 0; i < 32; i++) begin
            rw = DW'($urandom);
            fifo_q.push_back(rw);
        end
        tick();
        param_waddr = 32'h0000_2000;
        param_oolen = CW'(32);
        store_start = 1'b1;
        tick();
        store_start = 1'b0;
        for (int c = 0; c < 2000 && got_base.size() < 2; c++) @(negedge clk);
        chk("rst_burst2_seen", XDW'(got_base.size()), 2);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        tick();
        rst = 1'b0;
        fifo_q.delete();
        tick();
        run_tile(32'h0000_3000, 8, 30, -1, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wmst_from_out_fifo_tile.md
# wmst_from_out_fifo_tile

Moves one output tile from the on-chip output FIFO to external memory through the Avalon write master. Pops DW-bit words from the FIFO, packs WCNT = XDW/DW words into one XDW beat (word 0 in the LSB lane), pushes beats into the write master's user buffer, and issues one `go` per burst of up to BLEN words. It is the store-side counterpart of the weight/input read path and sits between the output FIFO and the write master.

## Interface
- `CW`, 16, width of word counters and lengths
- `DW`, 32, FIFO word width
- `XAW`, 32, external byte address width
- `XDW`, 128, write master data width (multiple of DW, WCNT = XDW/DW ≥ 2)
- `BLEN`, 8, max DW words per burst (multiple of WCNT)

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `store_start`  in  1  one-cycle pulse; latches parameters, starts tile
- `param_waddr`  in  XAW  tile byte base address (XDW-aligned)
- `param_oolen`  in  CW  tile length in DW words
- `store_done`  out  1  one-cycle pulse, tile fully written
- `store_fifo_pop`  out  1  pop request; data valid the cycle after
- `store_fifo_data`  in  DW  FIFO read data
- `store_fifo_empty`  in  1  FIFO empty
- `wmst_fixed_location`  out  1  tied 0
- `wmst_write_base`  out  XAW  burst byte base address
- `wmst_write_length`  out  XAW  burst length in bytes
- `wmst_go`  out  1  one-cycle burst start
- `wmst_done`  in  1  level; rising edge = burst complete
- `wmst_user_write_buffer`  out  1  beat push strobe
- `wmst_user_buffer_data`  out  XDW  beat data
- `wmst_user_buffer_full`  in  1  master buffer full

## Operation
- Length rounding: words = param_oolen rounded up to a multiple of WCNT; padded lanes carry 0 and are never popped from the FIFO.
- Control FSM: IDLE → (store_start, words>0) ISSUE → WAIT → ISSUE … → IDLE. store_start with words=0: store_done pulses next cycle, no go.
- ISSUE: one-cycle `wmst_go`; base = current address, length = min(burst_rem, BLEN)·(DW/8); then address += that length, burst_rem -= min. → WAIT.
- WAIT: on wmst_done rising edge (registered compare): burst_rem>0 → ISSUE, else store_done pulse and → IDLE.
- store_start outside IDLE is ignored.
- Pack path (independent of FSM, active while not IDLE): `store_fifo_pop` = !store_fifo_empty && pop_rem>0 && pops_in_beat<real_words_in_beat && !beat_valid. Popped word captured into lane pops_in_beat next cycle. When the beat's last lane (real or pad) is filled, beat_valid sets.
- `wmst_user_write_buffer` = beat_valid && !wmst_user_buffer_full; data held stable while valid; on push beat_valid clears, lane counter resets.
- Counters CW bits; byte address XAW bits, wraps modulo 2^XAW.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0, beat register 0. Reset mid-tile aborts immediately; FIFO contents not drained.
- store_start at cycle T → first wmst_go at T+1 with base=param_waddr.
- wmst_done rise seen at T → next go (or store_done) at T+1.
- First pop earliest T+1; beat of WCNT words pushed earliest WCNT+1 cycles after its first pop.
- Push and go are decoupled; data may enter the master buffer before its burst go.
- Pop and push never occur for the same beat in one cycle.

## Structure
- Shared package: WCNT, bytes-per-word, BLEN, FSM state encoding.
- Sub-module `wmst_beat_packer`: pop logic, lane capture, beat_valid/full handshake; top holds FSM, address/length counters, done edge detect.

## Test plan
- oolen=16, waddr=0x1000, FIFO holds 0..15 → beats {3,2,1,0}…{15,14,13,12}; go base 0x1000 len 32, then 0x1020 len 32; one store_done after second done.
- wmst_user_buffer_full high 10 cycles mid-tile → beat data/valid stable, no pops, no beat lost, order preserved.
- FIFO empty randomly 50% of cycles → identical beat sequence, pops only when non-empty.
- oolen=0 → store_done at T+1, no go, no pop.
- oolen=6 → 6 pops; beats {3,2,1,0},{0,0,5,4}; single go len 32.
- rst during second burst → all outputs 0 next cycle; fresh store_start oolen=8 completes normally.
